// File: rtl/pin_conditioner_if.sv
// Pad-side and core-side signals of the pin conditioner.
// The pad/bench side drives the pads as master; the conditioner is the slave.
interface pin_conditioner_if;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic       sys_rst_n;
    logic       rx_s;
    logic [3:0] gpio_i_s;
    logic       irq_level;
    logic       irq_pulse;
    logic       init_qspicmd;
    logic [1:0] init_latency;
    logic       init_cpu_start;
    logic [1:0] init_uart;
    logic       straps_valid;

    modport master (
        output ui_in, uio_in,
        input  sys_rst_n, rx_s, gpio_i_s, irq_level, irq_pulse,
        input  init_qspicmd, init_latency, init_cpu_start, init_uart, straps_valid
    );

    modport slave (
        input  ui_in, uio_in,
        output sys_rst_n, rx_s, gpio_i_s, irq_level, irq_pulse,
        output init_qspicmd, init_latency, init_cpu_start, init_uart, straps_valid
    );
endinterface

// File: rtl/pin_conditioner.sv
// Pad input conditioning: synchronizers, interrupt debounce, core reset
// sequencing and one-shot boot strap capture for fpga_top.
module pin_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 4,
    parameter int STRAP_DELAY = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    pin_conditioner_if.slave   pif
);
    localparam int WCW = $clog2(STRAP_DELAY + 1);
    localparam logic [WCW-1:0]        WAIT_LAST = WCW'(STRAP_DELAY - 1);
    localparam logic [WCW-1:0]        WAIT_ONE  = WCW'(1);
    localparam logic [DEBOUNCE_W-1:0] DMAX      = {DEBOUNCE_W{1'b1}};
    localparam logic [DEBOUNCE_W-1:0] DB_ONE    = DEBOUNCE_W'(1);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_LATCH = 2'd2,
        ST_RUN   = 2'd3
    } seq_state_t;

    logic [SYNC_STAGES-1:0]      rsync_chain_r;
    logic [SYNC_STAGES-1:0]      rx_chain_r;
    logic [SYNC_STAGES-1:0]      irq_chain_r;
    logic [SYNC_STAGES-1:0][5:0] strap_chain_r;
    logic [SYNC_STAGES-1:0][3:0] gpio_chain_r;

    seq_state_t                  state_r;
    logic [WCW-1:0]              wait_cnt_r;
    logic                        sys_rst_n_r;
    logic                        straps_valid_r;
    logic [5:0]                  init_r;

    logic [DEBOUNCE_W-1:0]       db_cnt_r;
    logic                        irq_level_r;
    logic                        irq_level_q_r;
    logic                        irq_pulse_r;

    logic                        rsync_s;
    logic                        irq_sync_s;
    logic                        mismatch_s;
    logic                        unused_pads_s;

    assign rsync_s       = rsync_chain_r[SYNC_STAGES-1];
    assign irq_sync_s    = irq_chain_r[SYNC_STAGES-1];
    assign mismatch_s    = irq_sync_s ^ irq_level_r;
    assign unused_pads_s = ^pif.uio_in[3:0];

    // Reset synchronizer: asynchronous assert, synchronous release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsync_chain_r <= {SYNC_STAGES{1'b0}};
        end else begin
            rsync_chain_r <= {rsync_chain_r[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Pad synchronizer chains; rx idles high so the UART sees no false start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_chain_r    <= {SYNC_STAGES{1'b1}};
            irq_chain_r   <= {SYNC_STAGES{1'b0}};
            strap_chain_r <= {(SYNC_STAGES*6){1'b0}};
            gpio_chain_r  <= {(SYNC_STAGES*4){1'b0}};
        end else begin
            rx_chain_r    <= {rx_chain_r[SYNC_STAGES-2:0], pif.ui_in[0]};
            irq_chain_r   <= {irq_chain_r[SYNC_STAGES-2:0], pif.ui_in[1]};
            strap_chain_r <= {strap_chain_r[SYNC_STAGES-2:0], pif.ui_in[7:2]};
            gpio_chain_r  <= {gpio_chain_r[SYNC_STAGES-2:0], pif.uio_in[7:4]};
        end
    end

    // Reset sequencer: wait for straps to settle, latch them once, release the core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_HOLD;
            wait_cnt_r     <= {WCW{1'b0}};
            sys_rst_n_r    <= 1'b0;
            straps_valid_r <= 1'b0;
            init_r         <= 6'b000000;
        end else begin
            case (state_r)
                ST_HOLD: begin
                    if (rsync_s) begin
                        state_r    <= ST_WAIT;
                        wait_cnt_r <= {WCW{1'b0}};
                    end else begin
                        state_r    <= ST_HOLD;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_r == WAIT_LAST) begin
                        state_r    <= ST_LATCH;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                    end
                end
                ST_LATCH: begin
                    state_r        <= ST_RUN;
                    init_r         <= strap_chain_r[SYNC_STAGES-1];
                    straps_valid_r <= 1'b1;
                    sys_rst_n_r    <= 1'b1;
                end
                ST_RUN: begin
                    state_r <= ST_RUN;
                end
                default: begin
                    state_r <= ST_HOLD;
                end
            endcase
        end
    end

    // Interrupt debounce: level follows the pad only after DMAX+1 steady mismatching cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_r    <= {DEBOUNCE_W{1'b0}};
            irq_level_r <= 1'b0;
        end else begin
            if (mismatch_s) begin
                if (db_cnt_r == DMAX) begin
                    irq_level_r <= irq_sync_s;
                    db_cnt_r    <= {DEBOUNCE_W{1'b0}};
                end else begin
                    db_cnt_r    <= db_cnt_r + DB_ONE;
                end
            end else begin
                db_cnt_r <= {DEBOUNCE_W{1'b0}};
            end
        end
    end

    // Rising-edge strobe; rises seen before RUN are dropped, not deferred.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_level_q_r <= 1'b0;
            irq_pulse_r   <= 1'b0;
        end else begin
            irq_level_q_r <= irq_level_r;
            irq_pulse_r   <= irq_level_r & ~irq_level_q_r & (state_r == ST_RUN);
        end
    end

    assign pif.sys_rst_n      = sys_rst_n_r;
    assign pif.rx_s           = rx_chain_r[SYNC_STAGES-1];
    assign pif.gpio_i_s       = gpio_chain_r[SYNC_STAGES-1];
    assign pif.irq_level      = irq_level_r;
    assign pif.irq_pulse      = irq_pulse_r;
    assign pif.init_uart      = init_r[5:4];
    assign pif.init_cpu_start = init_r[3];
    assign pif.init_latency   = init_r[2:1];
    assign pif.init_qspicmd   = init_r[0];
    assign pif.straps_valid   = straps_valid_r;
endmodule

// File: doc/pin_conditioner.md
# pin_conditioner

Input-side conditioning stage between the chip pads and `fpga_top`. It synchronizes the asynchronous pad inputs and debounces the external interrupt. It also sequences the core reset and latches the boot strap pins (`init_*`) once, after reset release. `fpga_top` consumes every output of this block; none of them go back to the pads.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: flip-flop depth of every synchronizer chain, including the reset synchronizer. Must be ≥ 2.
- `DEBOUNCE_W`, default 4: width of the interrupt debounce counter. DMAX = 2^DEBOUNCE_W − 1. Must be ≥ 1.
- `STRAP_DELAY`, default 8: number of cycles the sequencer waits for strap pins to settle before latching them. Must be ≥ 1.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ui_in`  in  8  dedicated pad inputs: [0] rx, [1] interrupt, [2] qspicmd strap, [4:3] latency strap, [5] cpu_start strap, [7:6] uart strap.
- `uio_in`  in  8  bidirectional pad inputs; only [7:4] (gpio) are used, [3:0] are ignored.
- `sys_rst_n`  out  1  core reset to `fpga_top`; active-low, registered.
- `rx_s`  out  1  synchronized rx.
- `gpio_i_s`  out  4  synchronized `uio_in[7:4]`.
- `irq_level`  out  1  debounced interrupt level.
- `irq_pulse`  out  1  one-cycle strobe on a rising edge of `irq_level`.
- `init_qspicmd`  out  1  latched strap.
- `init_latency`  out  2  latched strap.
- `init_cpu_start`  out  1  latched strap.
- `init_uart`  out  2  latched strap.
- `straps_valid`  out  1  high once the straps are latched.

## Operation

Synchronizers:
- Each of `ui_in[0]`, `ui_in[1]`, `ui_in[7:2]` and `uio_in[7:4]` passes through its own `SYNC_STAGES`-deep flop chain.
- The rx chain resets to 1 (UART idle). All other chains reset to 0.

Reset synchronizer:
- `SYNC_STAGES`-bit shift register, cleared asynchronously by `rst_n`.
- Shifts in 1 each cycle while `rst_n` is high. Its last bit is `rsync`.

Sequencer FSM (reset state HOLD):
- HOLD: stays in HOLD while `rsync` = 0. When `rsync` = 1, moves to WAIT and clears the counter.
- WAIT: the counter increments each cycle. When counter = `STRAP_DELAY` − 1, moves to LATCH.
- LATCH: moves to RUN. On this same edge, the synchronized `ui_in[7:2]` are captured into the `init_*` registers, and `straps_valid` and `sys_rst_n` are set to 1.
- RUN: terminal state. The straps are never re-captured; the pads may change freely afterwards.

Debounce:
- `mismatch` = (synchronized interrupt ≠ `irq_level`).
- While `mismatch` is high, the counter increments. While it is low, the counter clears.
- On an edge where counter = DMAX and `mismatch` is still high: `irq_level` takes the synchronized value and the counter clears.
- Debounce runs in every FSM state, since it is reset only by `rst_n`.

`irq_pulse`:
- Registered. Equals 1 for the one cycle after `irq_level` rises, but only if the FSM is in RUN.
- Otherwise 0, including for rises that happen before RUN; those are never replayed.

`rst_n` asserted at any time, including mid-WAIT or mid-debounce:
- All flops go to their reset values immediately, without waiting for a clock.
- Reset values: `sys_rst_n`=0, `rx_s`=1, `gpio_i_s`=0, `irq_level`=0, `irq_pulse`=0, `init_*`=0, `straps_valid`=0.

## Timing

- Edges are numbered 1, 2, … from the first rising `clk` after `rst_n` rises. S = `SYNC_STAGES`, D = `STRAP_DELAY`.
  - `rsync` = 1 after edge S.
  - WAIT is entered at edge S+1.
  - LATCH is entered at edge S+1+D.
  - `sys_rst_n`, `straps_valid` and `init_*` update at edge S+2+D. With defaults this is edge 12.
- Strap values captured: the pad levels present S or more cycles before edge S+2+D.
- Pad to `rx_s`/`gpio_i_s`: S edges.
- Interrupt pad change to `irq_level` change: S + DMAX + 1 edges, if the pad holds steady throughout. With defaults this is 18.
  - A pulse that stays high for fewer than DMAX+1 synchronized cycles produces no change on `irq_level`.
- `irq_pulse` is asserted on the edge after `irq_level` rises, for exactly one cycle.

## Test plan

- Strap latch:
  - Stimulus: `ui_in[7:2]`=6'b101101, then release `rst_n`.
  - Required: `sys_rst_n` and `straps_valid` rise at edge 12; `init_uart`=2'b10, `init_cpu_start`=1, `init_latency`=2'b10, `init_qspicmd`=1.
  - Afterwards, change the straps: the `init_*` outputs must be unchanged.
- Mid-sequence reset:
  - Stimulus: assert `rst_n` low during WAIT (edge 6).
  - Required: all outputs go to their reset values before the next edge. After re-release, `sys_rst_n` rises 12 edges later.
- Interrupt debounce:
  - Stimulus 1: in RUN, drive the interrupt high for 10 cycles, then low. Required: `irq_level` stays 0 and `irq_pulse` stays 0.
  - Stimulus 2: hold the interrupt high. Required: `irq_level` rises 18 edges after the pad; `irq_pulse` is high for exactly one cycle, one edge later.
- Suppressed pulse:
  - Stimulus: interrupt pad held high from reset.
  - Required: `irq_level` rises during WAIT (edge 18 is beyond 12 only if D is raised; run this with `STRAP_DELAY`=32); `irq_pulse` stays 0.
- Synchronizers:
  - Check reset values: `rx_s`=1, `gpio_i_s`=0.
  - Stimulus: toggle `uio_in[7:4]` to 4'hA. Required: `gpio_i_s`=4'hA exactly 2 edges later; `uio_in[3:0]` activity has no effect on any output.
